// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard unit and its multi-cycle scoreboard.
// Optional performance counters are enabled with HAZ_PERF_CNT_EN.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit signal bundle; pipeline side is master, hazard unit is slave.
// Counter outputs exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
);
  logic              branch_D, mcop_D, regwrite_D;
  logic [REG_AW-1:0] rs_D, rt_D, writereg_D;
  logic [REG_AW-1:0] rs_E, rt_E, writereg_E;
  logic              memtoreg_E, regwrite_E, mcop_E;
  logic [REG_AW-1:0] writereg_M;
  logic              memtoreg_M, regwrite_M;
  logic [REG_AW-1:0] writereg_W;
  logic              regwrite_W;

  logic              stall_F, stall_D, flush_E;
  logic              forwardA_D, forwardB_D;
  logic [1:0]        forwardA_E, forwardB_E;
  logic              mc_start, mc_busy, mc_wb_valid;
  logic [REG_AW-1:0] mc_wb_reg;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]  lw_stall_cnt, br_stall_cnt, mc_stall_cnt;
`endif

  modport master (
    output branch_D, mcop_D, regwrite_D, rs_D, rt_D, writereg_D,
    output rs_E, rt_E, writereg_E, memtoreg_E, regwrite_E, mcop_E,
    output writereg_M, memtoreg_M, regwrite_M, writereg_W, regwrite_W,
    input  stall_F, stall_D, flush_E, forwardA_D, forwardB_D,
    input  forwardA_E, forwardB_E, mc_start, mc_busy, mc_wb_valid, mc_wb_reg
`ifdef HAZ_PERF_CNT_EN
    , input lw_stall_cnt, br_stall_cnt, mc_stall_cnt
`endif
  );

  modport slave (
    input  branch_D, mcop_D, regwrite_D, rs_D, rt_D, writereg_D,
    input  rs_E, rt_E, writereg_E, memtoreg_E, regwrite_E, mcop_E,
    input  writereg_M, memtoreg_M, regwrite_M, writereg_W, regwrite_W,
    output stall_F, stall_D, flush_E, forwardA_D, forwardB_D,
    output forwardA_E, forwardB_E, mc_start, mc_busy, mc_wb_valid, mc_wb_reg
`ifdef HAZ_PERF_CNT_EN
    , output lw_stall_cnt, br_stall_cnt, mc_stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_scoreboard_mc_scoreboard.sv
// Single-entry scoreboard for the non-pipelined multi-cycle unit: tracks the
// pending destination and produces the start and writeback pulses.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_LAT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mcop_E,
  input  logic [REG_AW-1:0] writereg_E,
  output logic              mc_start,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_reg,
  output logic [REG_AW-1:0] pend_reg,
  output mc_state_t         state
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  // IDLE->BUSY takes one cycle and BUSY->DONE another, so the count covers the rest.
  localparam logic [CW-1:0] LOAD = CW'(MC_LAT - 2);

  mc_state_t     state_nxt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mcop_E) begin
        pend_reg <= writereg_E;
        cnt      <= LOAD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mcop_E) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mc_start    = (state == IDLE) && mcop_E;
    mc_busy     = (state != IDLE);
    mc_wb_valid = (state == DONE);
    mc_wb_reg   = (state == DONE) ? pend_reg : '0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline with a multi-cycle-unit scoreboard.
// Define HAZ_PERF_CNT_EN to add saturating stall counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_LAT = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   hz,
  output mc_state_t            mc_state
);

  logic              mc_busy, mc_wb_valid;
  logic [REG_AW-1:0] mc_wb_reg, pend_reg;
  logic              lwstall, branchstall, mcrawstall, mcwawstall, mcstructstall;
  logic              stall;

  mc_scoreboard #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) u_mc (
    .clk         (clk),
    .reset       (reset),
    .mcop_E      (hz.mcop_E),
    .writereg_E  (hz.writereg_E),
    .mc_start    (hz.mc_start),
    .mc_busy     (mc_busy),
    .mc_wb_valid (mc_wb_valid),
    .mc_wb_reg   (mc_wb_reg),
    .pend_reg    (pend_reg),
    .state       (mc_state)
  );

  // A register is pending once issued from E, not only after the scoreboard latches it.
  function automatic logic pend_hit(input logic [REG_AW-1:0] r, input logic busy,
                                    input logic [REG_AW-1:0] pend, input logic mcop,
                                    input logic [REG_AW-1:0] wr_e);
    return (r != '0) && ((busy && r == pend) || (mcop && r == wr_e));
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wr_m, input logic rw_m,
                                       input logic [REG_AW-1:0] wr_w, input logic rw_w,
                                       input logic wb_v, input logic [REG_AW-1:0] wb_r);
    if (src == '0)                return FWD_RF;
    else if (rw_m && src == wr_m) return FWD_M;
    else if (rw_w && src == wr_w) return FWD_W;
    else if (wb_v && src == wb_r) return FWD_MC;
    else                          return FWD_RF;
  endfunction

  always_comb begin
    lwstall = hz.memtoreg_E && (hz.writereg_E != '0) &&
              (hz.rs_D == hz.writereg_E || hz.rt_D == hz.writereg_E);
    branchstall = hz.branch_D &&
      ((hz.regwrite_E && hz.writereg_E != '0 &&
        (hz.rs_D == hz.writereg_E || hz.rt_D == hz.writereg_E)) ||
       (hz.memtoreg_M && hz.writereg_M != '0 &&
        (hz.rs_D == hz.writereg_M || hz.rt_D == hz.writereg_M)));
    mcrawstall    = pend_hit(hz.rs_D, mc_busy, pend_reg, hz.mcop_E, hz.writereg_E) ||
                    pend_hit(hz.rt_D, mc_busy, pend_reg, hz.mcop_E, hz.writereg_E);
    mcwawstall    = hz.regwrite_D &&
                    pend_hit(hz.writereg_D, mc_busy, pend_reg, hz.mcop_E, hz.writereg_E);
    mcstructstall = hz.mcop_D && (mc_busy || hz.mcop_E);
    stall = lwstall || branchstall || mcrawstall || mcwawstall || mcstructstall;
  end

  always_comb begin
    hz.stall_F     = stall;
    hz.stall_D     = stall;
    hz.flush_E     = stall;
    hz.forwardA_D  = (hz.rs_D != '0) && (hz.rs_D == hz.writereg_M) && hz.regwrite_M;
    hz.forwardB_D  = (hz.rt_D != '0) && (hz.rt_D == hz.writereg_M) && hz.regwrite_M;
    hz.forwardA_E  = fwd_e(hz.rs_E, hz.writereg_M, hz.regwrite_M, hz.writereg_W,
                           hz.regwrite_W, mc_wb_valid, mc_wb_reg);
    hz.forwardB_E  = fwd_e(hz.rt_E, hz.writereg_M, hz.regwrite_M, hz.writereg_W,
                           hz.regwrite_W, mc_wb_valid, mc_wb_reg);
    hz.mc_busy     = mc_busy;
    hz.mc_wb_valid = mc_wb_valid;
    hz.mc_wb_reg   = mc_wb_reg;
  end

`ifdef HAZ_PERF_CNT_EN
  logic mcstall;
  assign mcstall = mcrawstall || mcwawstall || mcstructstall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz.lw_stall_cnt <= '0;
      hz.br_stall_cnt <= '0;
      hz.mc_stall_cnt <= '0;
    end else begin
      if (lwstall && !(&hz.lw_stall_cnt))     hz.lw_stall_cnt <= hz.lw_stall_cnt + 1'b1;
      if (branchstall && !(&hz.br_stall_cnt)) hz.br_stall_cnt <= hz.br_stall_cnt + 1'b1;
      if (mcstall && !(&hz.mc_stall_cnt))     hz.mc_stall_cnt <= hz.mc_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MC_LAT=16); counter checks compile in with HAZ_PERF_CNT_EN.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 16;
  localparam int CNT_W  = 32;

  logic      clk;
  logic      reset;
  mc_state_t mc_state;
  int        checks;
  int        errors;
  int        wb_cnt;
  int        wb_before;
  logic [REG_AW-1:0] exp_q[$];

  hazard_scoreboard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

  hazard_scoreboard #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .hz       (hif.slave),
    .mc_state (mc_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // writeback pulse counter and the DONE/issue exclusion
  initial wb_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (hif.mc_wb_valid) wb_cnt++;
      if (mc_state == DONE && hif.mcop_E) check("done_vs_issue", 32'd1, 32'd0);
    end
  end

  // driver tasks
  task automatic clear_inputs();
    hif.branch_D = 0; hif.mcop_D = 0; hif.regwrite_D = 0;
    hif.rs_D = 0; hif.rt_D = 0; hif.writereg_D = 0;
    hif.rs_E = 0; hif.rt_E = 0; hif.writereg_E = 0;
    hif.memtoreg_E = 0; hif.regwrite_E = 0; hif.mcop_E = 0;
    hif.writereg_M = 0; hif.memtoreg_M = 0; hif.regwrite_M = 0;
    hif.writereg_W = 0; hif.regwrite_W = 0;
  endtask

  // advance one cycle; scoreboard pops the expected writeback register on the strobe
  task automatic tick();
    @(posedge clk);
    #1;
    if (hif.mc_wb_valid) begin
      if (exp_q.size() > 0) check("wb_reg", 32'(hif.mc_wb_reg), 32'(exp_q.pop_front()));
      else                  check("wb_unexpected", 32'd1, 32'd0);
    end
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd);
    hif.mcop_E = 1; hif.writereg_E = rd;
    exp_q.push_back(rd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(mc_state), 32'(IDLE));
    check("rst_busy", 32'(hif.mc_busy), 0);
    check("rst_wb", 32'(hif.mc_wb_valid), 0);
    check("rst_stall", {29'd0, hif.stall_F, hif.stall_D, hif.flush_E}, 0);
    check("rst_fwd", {26'd0, hif.forwardA_D, hif.forwardB_D, hif.forwardA_E, hif.forwardB_E}, 0);
    reset = 0;

    // load-use
    tick();
    hif.memtoreg_E = 1; hif.writereg_E = 8; hif.rs_D = 8;
    #1;
    check("lw_stall", {29'd0, hif.stall_F, hif.stall_D, hif.flush_E}, 32'h7);
    tick();
    hif.rs_D = 0; hif.writereg_E = 0;
    #1;
    check("lw_r0_nostall", 32'(hif.stall_F), 0);
`ifdef HAZ_PERF_CNT_EN
    check("lw_cnt", hif.lw_stall_cnt, 1);
`endif
    clear_inputs();

    // branch compare hazard, then forwarding into D
    tick();
    hif.branch_D = 1; hif.rs_D = 4; hif.regwrite_E = 1; hif.writereg_E = 4;
    #1;
    check("br_stall", 32'(hif.stall_D), 1);
    tick();
    hif.regwrite_E = 0; hif.writereg_E = 0; hif.writereg_M = 4; hif.regwrite_M = 1;
    #1;
    check("br_fwdA_D", 32'(hif.forwardA_D), 1);
    check("br_fwdB_D", 32'(hif.forwardB_D), 0);
    check("br_nostall", 32'(hif.stall_D), 0);
`ifdef HAZ_PERF_CNT_EN
    check("br_cnt", hif.br_stall_cnt, 1);
`endif
    clear_inputs();

    // E-stage forwarding priority
    tick();
    hif.rs_E = 5; hif.rt_E = 6; hif.writereg_M = 5; hif.regwrite_M = 1;
    hif.writereg_W = 5; hif.regwrite_W = 1;
    #1;
    check("fwdA_E_M", 32'(hif.forwardA_E), 32'(FWD_M));
    check("fwdB_E_none", 32'(hif.forwardB_E), 32'(FWD_RF));
    hif.regwrite_M = 0;
    #1;
    check("fwdA_E_W", 32'(hif.forwardA_E), 32'(FWD_W));
    hif.rs_E = 0; hif.writereg_W = 0;
    #1;
    check("fwdA_E_r0", 32'(hif.forwardA_E), 32'(FWD_RF));
    clear_inputs();

    // multi-cycle issue to $12 with a dependent instruction in D
    tick();
    issue(12); hif.rs_D = 12;
    #1;
    check("mc_start", 32'(hif.mc_start), 1);
    check("mc_raw_issue", 32'(hif.stall_F), 1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      hif.mcop_E = 0; hif.writereg_E = 0;
      hif.rt_E = (k == 16) ? 5'd12 : 5'd0;
      #1;
      check($sformatf("mc_busy_%0d", k), 32'(hif.mc_busy), 32'(k <= 16));
      check($sformatf("mc_raw_%0d", k), 32'(hif.stall_F), 32'(k <= 16));
      check($sformatf("mc_wbv_%0d", k), 32'(hif.mc_wb_valid), 32'(k == 16));
      check($sformatf("mc_start_%0d", k), 32'(hif.mc_start), 0);
      if (k == 16) begin
        check("mc_done_state", 32'(mc_state), 32'(DONE));
        check("mc_fwdB_E", 32'(hif.forwardB_E), 32'(FWD_MC));
      end
    end
    check("wb_count_1", wb_cnt, 1);
`ifdef HAZ_PERF_CNT_EN
    check("mc_cnt", hif.mc_stall_cnt, 17);
`endif
    clear_inputs();

    // structural and WAW stalls behind a busy unit
    tick();
    issue(12);
    #1;
    check("mc2_start", 32'(hif.mc_start), 1);
    check("mc2_nostall", 32'(hif.stall_F), 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      hif.mcop_E = 0; hif.writereg_E = 0;
      hif.mcop_D     = ((k >= 2 && k <= 4) || k >= 10);
      hif.regwrite_D = (k == 5 || k == 6);
      hif.writereg_D = (k == 5) ? 5'd12 : ((k == 6) ? 5'd13 : 5'd0);
      hif.rs_E       = (k == 16) ? 5'd12 : 5'd0;
      hif.writereg_M = (k == 16) ? 5'd12 : 5'd0;
      hif.regwrite_M = (k == 16);
      #1;
      check($sformatf("sw_stall_%0d", k), 32'(hif.stall_D),
            32'(((k >= 2 && k <= 5) || (k >= 10 && k <= 16))));
      if (k == 16) check("mc2_fwdA_E_M", 32'(hif.forwardA_E), 32'(FWD_M));
    end
    check("wb_count_2", wb_cnt, 2);
    clear_inputs();

    // reset in the middle of BUSY abandons the pending write
    tick();
    issue(12);
    #1;
    check("mc3_start", 32'(hif.mc_start), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      hif.mcop_E = 0; hif.writereg_E = 0;
    end
    wb_before = wb_cnt;
    reset = 1;
    exp_q.delete();
    #1;
    check("rst_mid_busy", 32'(hif.mc_busy), 0);
    check("rst_mid_state", 32'(mc_state), 32'(IDLE));
    check("rst_mid_wb", 32'(hif.mc_wb_valid), 0);
`ifdef HAZ_PERF_CNT_EN
    check("rst_lw_cnt", hif.lw_stall_cnt, 0);
    check("rst_br_cnt", hif.br_stall_cnt, 0);
    check("rst_mc_cnt", hif.mc_stall_cnt, 0);
`endif
    tick();
    reset = 0;
    hif.rs_D = 12;
    #1;
    check("rst_mid_nostall", 32'(hif.stall_F), 0);
    repeat (20) tick();
    check("rst_no_wb", wb_cnt, wb_before);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
